// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage of a 5-stage LEGv8 pipeline.
//
// Issues word-aligned requests to instruction memory (at most two in flight),
// buffers the returned instructions together with their PCs in a small FIFO,
// and presents the FIFO head to decode. Branch information resolved in decode
// redirects the fetch PC. Requests still in flight at the moment of a redirect
// are remembered in drop_cnt so that their responses are discarded when they
// come back. A taken BL also produces the X30 link value one cycle later.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   imem_req/imem_addr      request to instruction memory (addr word aligned)
//   imem_gnt                memory accepts the current request
//   imem_rvalid/imem_rdata  in-order response from instruction memory
//   if_valid/if_instr/if_pc FIFO head offered to decode
//   id_ready                decode consumes the head when if_valid && id_ready
//   br_pc, BrTaken, UncondBr, breg_sig, blink_sig, imm26, imm19, reg_target
//                           branch resolution from decode
//   link_valid/link_addr    registered BL link value (br_pc + 4)
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int                ADDR_W     = 64,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    input  logic              id_ready,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic              BrTaken,
    input  logic              UncondBr,
    input  logic              breg_sig,
    input  logic              blink_sig,
    input  logic [25:0]       imm26,
    input  logic [18:0]       imm19,
    input  logic [ADDR_W-1:0] reg_target,
    output logic              link_valid,
    output logic [ADDR_W-1:0] link_addr
);

    localparam int                PTR_W   = $clog2(FIFO_DEPTH);
    localparam int                CNT_W   = PTR_W + 1;
    localparam int                SUM_W   = CNT_W + 1;
    localparam logic [SUM_W-1:0]  DEPTH_C = SUM_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] PC_STEP = {{(ADDR_W-3){1'b0}}, 3'd4};
    localparam logic [1:0]        MAX_OUT = 2'd2;

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    // Branch offsets are word counts: sign extend and scale by 4.
    function automatic logic [ADDR_W-1:0] sext_imm26_x4(input logic [25:0] imm);
        return {{(ADDR_W-28){imm[25]}}, imm, 2'b00};
    endfunction

    function automatic logic [ADDR_W-1:0] sext_imm19_x4(input logic [18:0] imm);
        return {{(ADDR_W-21){imm[18]}}, imm, 2'b00};
    endfunction

    // Register targets may carry low bits; instructions are word aligned.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

    state_t              state_r;
    logic [ADDR_W-1:0]   fetch_pc_r;
    logic [ADDR_W-1:0]   resp_pc_r;
    logic [1:0]          outstanding_r;
    logic [1:0]          drop_cnt_r;
    logic [CNT_W-1:0]    count_r;
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [31:0]         instr_mem_r [FIFO_DEPTH];
    logic [ADDR_W-1:0]   pc_mem_r    [FIFO_DEPTH];
    logic                link_valid_r;
    logic [ADDR_W-1:0]   link_addr_r;

    logic [ADDR_W-1:0]   target_s;
    logic [SUM_W-1:0]    occupancy_s;
    logic                fetch_ok_s;
    logic                grant_s;
    logic                push_s;
    logic                pop_s;
    logic [1:0]          out_next_s;
    logic [1:0]          drop_next_s;
    logic [CNT_W-1:0]    count_next_s;

    // Redirect target selection: BR beats the immediate forms.
    always_comb begin
        target_s = {ADDR_W{1'b0}};
        if (breg_sig) begin
            target_s = word_align(reg_target);
        end else if (UncondBr) begin
            target_s = br_pc + sext_imm26_x4(imm26);
        end else begin
            target_s = br_pc + sext_imm19_x4(imm19);
        end
    end

    // Request gating: FIFO space is reserved for every request in flight so
    // a returning response can always be pushed.
    always_comb begin
        occupancy_s = SUM_W'(count_r) + SUM_W'(outstanding_r);
        fetch_ok_s  = 1'b0;
        if ((state_r == ST_FETCH) && (occupancy_s < DEPTH_C) && (outstanding_r < MAX_OUT)) begin
            fetch_ok_s = 1'b1;
        end else begin
            fetch_ok_s = 1'b0;
        end
    end

    // Bookkeeping for this edge: in-flight count, drop counter, FIFO moves.
    always_comb begin
        grant_s    = imem_req && imem_gnt;
        out_next_s = outstanding_r + {1'b0, grant_s} - {1'b0, imem_rvalid};
        if (imem_rvalid && (drop_cnt_r != 2'd0)) begin
            drop_next_s = drop_cnt_r - 2'd1;
        end else begin
            drop_next_s = drop_cnt_r;
        end
        // A redirect discards any same-cycle response and blocks the pop.
        push_s       = imem_rvalid && (drop_cnt_r == 2'd0) && !BrTaken;
        pop_s        = (count_r != {CNT_W{1'b0}}) && id_ready && !BrTaken;
        count_next_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
    end

    // The gating terms are all registered; reset_n only forces the request
    // low while reset is held.
    assign imem_req   = reset_n && fetch_ok_s;
    assign imem_addr  = fetch_pc_r;
    assign if_valid   = (count_r != {CNT_W{1'b0}});
    assign if_instr   = instr_mem_r[rd_ptr_r];
    assign if_pc      = pc_mem_r[rd_ptr_r];
    assign link_valid = link_valid_r;
    assign link_addr  = link_addr_r;

    // Control FSM, PCs, in-flight/drop counters, FIFO pointers and link value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_FETCH;
            fetch_pc_r    <= RESET_PC;
            resp_pc_r     <= RESET_PC;
            outstanding_r <= 2'd0;
            drop_cnt_r    <= 2'd0;
            count_r       <= {CNT_W{1'b0}};
            wr_ptr_r      <= {PTR_W{1'b0}};
            rd_ptr_r      <= {PTR_W{1'b0}};
            link_valid_r  <= 1'b0;
            link_addr_r   <= {ADDR_W{1'b0}};
        end else begin
            outstanding_r <= out_next_s;
            link_valid_r  <= BrTaken && blink_sig;
            if (BrTaken && blink_sig) begin
                link_addr_r <= br_pc + PC_STEP;
            end else begin
                link_addr_r <= link_addr_r;
            end

            if (BrTaken) begin
                // Everything still in flight after this edge belongs to the
                // old path, including a request granted on this very edge.
                fetch_pc_r <= target_s;
                resp_pc_r  <= target_s;
                drop_cnt_r <= out_next_s;
                count_r    <= {CNT_W{1'b0}};
                wr_ptr_r   <= {PTR_W{1'b0}};
                rd_ptr_r   <= {PTR_W{1'b0}};
                if (out_next_s != 2'd0) begin
                    state_r <= ST_DRAIN;
                end else begin
                    state_r <= ST_FETCH;
                end
            end else begin
                drop_cnt_r <= drop_next_s;
                count_r    <= count_next_s;
                if (grant_s) begin
                    fetch_pc_r <= fetch_pc_r + PC_STEP;
                end else begin
                    fetch_pc_r <= fetch_pc_r;
                end
                if (push_s) begin
                    resp_pc_r <= resp_pc_r + PC_STEP;
                    wr_ptr_r  <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
                end else begin
                    resp_pc_r <= resp_pc_r;
                    wr_ptr_r  <= wr_ptr_r;
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
                end else begin
                    rd_ptr_r <= rd_ptr_r;
                end
                case (state_r)
                    ST_FETCH: state_r <= ST_FETCH;
                    ST_DRAIN: begin
                        if (drop_next_s == 2'd0) begin
                            state_r <= ST_FETCH;
                        end else begin
                            state_r <= ST_DRAIN;
                        end
                    end
                    default: state_r <= ST_FETCH;
                endcase
            end
        end
    end

    // FIFO storage: write the accepted response at the tail.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                instr_mem_r[i] <= 32'd0;
                pc_mem_r[i]    <= {ADDR_W{1'b0}};
            end
        end else if (push_s) begin
            instr_mem_r[wr_ptr_r] <= imem_rdata;
            pc_mem_r[wr_ptr_r]    <= resp_pc_r;
        end else begin
            instr_mem_r[wr_ptr_r] <= instr_mem_r[wr_ptr_r];
            pc_mem_r[wr_ptr_r]    <= pc_mem_r[wr_ptr_r];
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit: a table of redirect vectors with hand-computed
// targets and link values, plus hand-written sequences for reset latency,
// FIFO fill under decode stall, dropping two in-flight responses, a not-taken
// CBZ and reset during DRAIN. The instruction memory model returns
// instr_of(addr) in order, one cycle after grant unless mem_stall holds it.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic        id_ready;
    logic [63:0] br_pc;
    logic        BrTaken;
    logic        UncondBr;
    logic        breg_sig;
    logic        blink_sig;
    logic [25:0] imm26;
    logic [18:0] imm19;
    logic [63:0] reg_target;
    logic        link_valid;
    logic [63:0] link_addr;

    int errors = 0;
    int checks = 0;

    fetch_unit dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .id_ready   (id_ready),
        .br_pc      (br_pc),
        .BrTaken    (BrTaken),
        .UncondBr   (UncondBr),
        .breg_sig   (breg_sig),
        .blink_sig  (blink_sig),
        .imm26      (imm26),
        .imm19      (imm19),
        .reg_target (reg_target),
        .link_valid (link_valid),
        .link_addr  (link_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return ~a[31:0];
    endfunction

    // ---------------- instruction memory model ----------------
    logic        mem_stall;
    logic [63:0] mem_q [$];
    logic        s_grant;
    logic        s_rv;
    logic [63:0] s_addr;

    initial begin
        s_grant     = 1'b0;
        s_rv        = 1'b0;
        s_addr      = 64'd0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        fork
            forever begin
                @(negedge clk);
                if (reset_n) begin
                    s_grant = imem_req && imem_gnt;
                    s_addr  = imem_addr;
                    s_rv    = imem_rvalid;
                end else begin
                    s_grant = 1'b0;
                    s_rv    = 1'b0;
                end
            end
            forever begin
                @(posedge clk);
                #2;
                if (!reset_n) begin
                    mem_q.delete();
                    imem_rvalid = 1'b0;
                    imem_rdata  = 32'd0;
                end else begin
                    if (s_rv && (mem_q.size() > 0)) void'(mem_q.pop_front());
                    if (s_grant) mem_q.push_back(s_addr);
                    imem_rvalid = (mem_q.size() > 0) && !mem_stall;
                    imem_rdata  = (mem_q.size() > 0) ? instr_of(mem_q[0]) : 32'd0;
                end
                s_grant = 1'b0;
                s_rv    = 1'b0;
            end
        join
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n;
        n = 0;
        while (!if_valid && n < budget) begin
            tick();
            n++;
        end
        if (!if_valid) begin
            checks++;
            errors++;
            $display("FAIL %s: if_valid still 0 after %0d cycles", name, budget);
        end
    endtask

    task automatic wait_req_low(input string name, input int budget);
        int n;
        n = 0;
        while (imem_req && n < budget) begin
            tick();
            n++;
        end
        if (imem_req) begin
            checks++;
            errors++;
            $display("FAIL %s: imem_req still 1 after %0d cycles", name, budget);
        end
    endtask

    task automatic clr_br();
        br_pc      = 64'd0;
        BrTaken    = 1'b0;
        UncondBr   = 1'b0;
        breg_sig   = 1'b0;
        blink_sig  = 1'b0;
        imm26      = 26'd0;
        imm19      = 19'd0;
        reg_target = 64'd0;
    endtask

    typedef struct {
        logic [63:0] br_pc;
        logic        uncond;
        logic        breg;
        logic        blink;
        logic [25:0] imm26;
        logic [18:0] imm19;
        logic [63:0] reg_target;
        logic [63:0] exp_pc;
        logic        exp_lv;
        logic [63:0] exp_la;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        //            br_pc        U     R     L     imm26          imm19       reg_target    exp_pc                  lv    la
        vecs[0] = '{64'h40,   1'b1, 1'b0, 1'b0, 26'h3FFFFFE, 19'h00000, 64'h0,    64'h38,                 1'b0, 64'h0};
        vecs[1] = '{64'h100,  1'b1, 1'b0, 1'b1, 26'h0000004, 19'h00000, 64'h0,    64'h110,                1'b1, 64'h104};
        vecs[2] = '{64'h200,  1'b0, 1'b1, 1'b0, 26'h0000000, 19'h00000, 64'h2003, 64'h2000,               1'b0, 64'h0};
        vecs[3] = '{64'h2000, 1'b0, 1'b0, 1'b0, 26'h0000000, 19'h7FFFF, 64'h0,    64'h1FFC,               1'b0, 64'h0};
        vecs[4] = '{64'h1000, 1'b0, 1'b0, 1'b0, 26'h0000000, 19'h00010, 64'h0,    64'h1040,               1'b0, 64'h0};
        vecs[5] = '{64'h0,    1'b1, 1'b0, 1'b1, 26'h2000000, 19'h00000, 64'h0,    64'hFFFFFFFF_F8000000,  1'b1, 64'h4};
        vecs[6] = '{64'h300,  1'b1, 1'b1, 1'b0, 26'h0000005, 19'h00000, 64'h3000, 64'h3000,               1'b0, 64'h0};
        vecs[7] = '{64'h500,  1'b0, 1'b1, 1'b1, 26'h0000000, 19'h00000, 64'h4007, 64'h4004,               1'b1, 64'h504};

        reset_n   = 1'b0;
        imem_gnt  = 1'b1;
        id_ready  = 1'b1;
        mem_stall = 1'b0;
        clr_br();

        // Reset values and first fetches.
        repeat (2) tick();
        check("rst_req", imem_req, 64'd0);
        check("rst_valid", if_valid, 64'd0);
        check("rst_link_valid", link_valid, 64'd0);
        check("rst_link_addr", link_addr, 64'd0);
        reset_n = 1'b1;
        #1;
        check("boot_req0", imem_req, 64'd1);
        check("boot_addr0", imem_addr, 64'h0);
        tick();
        check("boot_addr4", imem_addr, 64'h4);
        tick();
        check("boot_addr8", imem_addr, 64'h8);
        check("boot_valid", if_valid, 64'd1);
        check("boot_pc", if_pc, 64'h0);
        check("boot_instr", {32'd0, if_instr}, {32'd0, instr_of(64'h0)});

        // Decode stalled: FIFO fills to four entries and requests stop.
        tick();
        reset_n  = 1'b0;
        id_ready = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (10) tick();
        check("fill_req_off", imem_req, 64'd0);
        check("fill_valid", if_valid, 64'd1);
        id_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("fill_valid%0d", k), if_valid, 64'd1);
            check($sformatf("fill_pc%0d", k), if_pc, 64'(4 * k));
            check($sformatf("fill_instr%0d", k), {32'd0, if_instr}, {32'd0, instr_of(64'(4 * k))});
            tick();
        end

        // Two requests in flight when B redirects: both responses dropped.
        mem_stall = 1'b1;
        wait_req_low("drop_wait_req", 10);
        br_pc    = 64'h40;
        UncondBr = 1'b1;
        imm26    = 26'h3FFFFFE;
        BrTaken  = 1'b1;
        tick();
        clr_br();
        check("drop_flush", if_valid, 64'd0);
        check("drop_drain_req", imem_req, 64'd0);
        mem_stall = 1'b0;
        wait_valid("drop_wait_valid", 20);
        check("drop_first_pc", if_pc, 64'h38);
        check("drop_first_instr", {32'd0, if_instr}, {32'd0, instr_of(64'h38)});
        tick();
        check("drop_second_pc", if_pc, 64'h3C);
        repeat (3) tick();

        // Table of redirects from steady streaming.
        for (int i = 0; i < NV; i++) begin
            br_pc      = vecs[i].br_pc;
            UncondBr   = vecs[i].uncond;
            breg_sig   = vecs[i].breg;
            blink_sig  = vecs[i].blink;
            imm26      = vecs[i].imm26;
            imm19      = vecs[i].imm19;
            reg_target = vecs[i].reg_target;
            BrTaken    = 1'b1;
            tick();
            clr_br();
            check($sformatf("v%0d_flush", i), if_valid, 64'd0);
            check($sformatf("v%0d_link_valid", i), link_valid, 64'(vecs[i].exp_lv));
            if (vecs[i].exp_lv) check($sformatf("v%0d_link_addr", i), link_addr, vecs[i].exp_la);
            tick();
            check($sformatf("v%0d_link_pulse", i), link_valid, 64'd0);
            wait_valid($sformatf("v%0d_wait", i), 20);
            check($sformatf("v%0d_pc", i), if_pc, vecs[i].exp_pc);
            check($sformatf("v%0d_instr", i), {32'd0, if_instr}, {32'd0, instr_of(vecs[i].exp_pc)});
            repeat (3) tick();
        end

        // CBZ not taken: no redirect, no link, stream continues.
        begin
            logic [63:0] p;
            wait_valid("nt_wait", 10);
            p         = if_pc;
            br_pc     = 64'h700;
            imm19     = 19'h00020;
            blink_sig = 1'b1;
            BrTaken   = 1'b0;
            tick();
            clr_br();
            check("nt_valid", if_valid, 64'd1);
            check("nt_pc1", if_pc, p + 64'd4);
            check("nt_link", link_valid, 64'd0);
            tick();
            check("nt_pc2", if_pc, p + 64'd8);
        end

        // Reset asserted while draining after a BL.
        mem_stall = 1'b1;
        wait_req_low("rd_wait_req", 10);
        br_pc     = 64'h800;
        UncondBr  = 1'b1;
        imm26     = 26'h0000008;
        blink_sig = 1'b1;
        BrTaken   = 1'b1;
        tick();
        clr_br();
        check("rd_link_valid", link_valid, 64'd1);
        check("rd_link_addr", link_addr, 64'h804);
        check("rd_drain_req", imem_req, 64'd0);
        reset_n = 1'b0;
        #1;
        check("rd_req", imem_req, 64'd0);
        check("rd_valid", if_valid, 64'd0);
        check("rd_lv", link_valid, 64'd0);
        check("rd_la", link_addr, 64'd0);
        mem_stall = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        #1;
        check("rd_restart_req", imem_req, 64'd1);
        check("rd_restart_addr", imem_addr, 64'h0);
        wait_valid("rd_wait_valid", 10);
        check("rd_restart_pc", if_pc, 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
